alu_exec_unit: RTL and testbench
================================

Name: alu_exec_unit

Overview:
- Parametrised successor to the ALU control decode: merges ALUOp/funct decode with a registered execute datapath.
- Adds multi-cycle iterative multiply and unsigned divide, plus a busy/stall handshake toward the pipeline hazard logic.
- Sits in the EX stage; it replaces the separate control-decode and single-cycle ALU pair.
- Single-cycle ops complete in 1 clock; MUL and DIVU take WIDTH clocks while `busy_o` stalls upstream.

Parameters:
- WIDTH, 32: operand, result and remainder width in bits (>=4).
- CNT_W, $clog2(WIDTH): iteration counter width. Derived; do not override.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  synchronous, active-high reset.
- valid_i  input  1  operation request; sampled only when the unit is idle.
- ALUOp_i  input  2  00=ADD, 01=SUB, 10=decode `funct_i`, 11=OR.
- funct_i  input  6  R-type function field; used only when ALUOp_i=10.
- data1_i  input  WIDTH  operand A (dividend, multiplicand).
- data2_i  input  WIDTH  operand B (divisor, multiplier).
- result_o  output  WIDTH  registered result (low product for MUL, quotient for DIVU).
- rem_o  output  WIDTH  registered high product for MUL, remainder for DIVU, 0 otherwise.
- zero_o  output  1  registered; 1 when result_o==0.
- valid_o  output  1  1-cycle pulse; result_o, rem_o and zero_o are valid in that cycle.
- busy_o  output  1  1 while a MUL or DIVU is in progress; upstream must hold the pipeline.

Behaviour:
- Decode when ALUOp_i=10:
  - 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT (signed), 011000 MUL, 011011 DIVU.
  - Any other funct decodes as ADD.
- Reset: state=IDLE; result_o=0, rem_o=0, zero_o=0, valid_o=0, busy_o=0; counter and internal operand registers cleared.
- States: IDLE, MUL, DIV. busy_o = (state != IDLE), decoded from state only.
- IDLE, valid_i=1, single-cycle op:
  - At the edge: result_o <= op result, rem_o <= 0, zero_o updated, valid_o <= 1.
  - State stays IDLE. Latency is 1 edge.
- IDLE, valid_i=1, MUL or DIVU:
  - Acceptance edge k latches operands, clears counter and partial registers, enters MUL or DIV. valid_o <= 0.
- MUL: unsigned shift-add, one multiplier bit per cycle, over iteration edges k+1 .. k+WIDTH.
- DIV: unsigned restoring divide, one quotient bit per cycle, over iteration edges k+1 .. k+WIDTH.
- Completion: at edge k+WIDTH, result_o and rem_o update, zero_o updates, valid_o <= 1, state <= IDLE. Total latency is WIDTH edges.
- valid_o is high for exactly one cycle per accepted op and is cleared on the next edge unless another single-cycle op completes.
- Back-to-back issue:
  - A new op may be accepted in the same cycle valid_o is high, because state is IDLE.
  - Single-cycle ops can complete every cycle, with valid_o held high continuously.
- valid_i while busy_o=1: ignored, no queueing. result_o, rem_o and zero_o keep their last values until completion.
- Arithmetic:
  - ADD/SUB wrap modulo 2^WIDTH; no overflow flag.
  - SLT gives 1 if signed A < signed B, else 0.
  - MUL is unsigned, full 2*WIDTH product, split as {rem_o, result_o}.
- DIVU by zero: result_o = all ones, rem_o = data1_i (the natural restoring outcome). No trap.
- Operands and decode are captured at acceptance; input changes during MUL/DIV have no effect.
- rst_i mid-operation: the next edge aborts the operation, returns to IDLE and clears all outputs. No valid_o pulse is produced for the aborted op.
- rst_i together with valid_i: reset wins; the request is dropped.

Test Plan:
- Reset, then ALUOp=10 funct=100010 with A=5, B=5 -> next cycle result_o=0, zero_o=1, valid_o=1 for 1 cycle; busy_o stays 0.
- Four back-to-back single-cycle ops, one per cycle (ADD 3+4, AND 0xF0&0x3C, OR, SLT -1<1) -> valid_o high 4 consecutive cycles with results 7, 0x30, OR result, 1.
- MUL A=0xFFFFFFFF, B=2 -> busy_o high 32 cycles; valid_o at edge k+32 with result_o=0xFFFFFFFE, rem_o=1. An extra valid_i pulse at k+10 is ignored.
- DIVU checks:
  - 100/7 -> result_o=14, rem_o=2, latency 32.
  - 100/0 -> result_o=0xFFFFFFFF, rem_o=100.
- rst_i at edge k+15 of a MUL -> busy_o=0, all outputs 0 next cycle, no valid_o. A new ADD issued next is accepted normally.
- ALUOp=00, 01, 11 with funct=011000 -> ADD, SUB, OR respectively, each in 1 cycle; MUL is not started.

Source files
------------

// File: rtl/alu_exec_unit.sv
// EX-stage ALU: ALUOp/funct decode, single-cycle ops, and iterative MUL/DIVU
// with a busy stall toward the hazard unit.
module alu_exec_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = $clog2(WIDTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    input  logic [1:0]       ALUOp_i,
    input  logic [5:0]       funct_i,
    input  logic [WIDTH-1:0] data1_i,
    input  logic [WIDTH-1:0] data2_i,
    output logic [WIDTH-1:0] result_o,
    output logic [WIDTH-1:0] rem_o,
    output logic             zero_o,
    output logic             valid_o,
    output logic             busy_o
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_AND  = 3'd2;
    localparam logic [2:0] OP_OR   = 3'd3;
    localparam logic [2:0] OP_SLT  = 3'd4;
    localparam logic [2:0] OP_MUL  = 3'd5;
    localparam logic [2:0] OP_DIVU = 3'd6;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic [1:0]       state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [WIDTH-1:0] acc, acc_n;   // partial high product / partial remainder
    logic [WIDTH-1:0] mq, mq_n;     // multiplier / dividend, shifts into low product / quotient
    logic [WIDTH-1:0] opb, opb_n;   // multiplicand / divisor
    logic [WIDTH-1:0] result_n, rem_n;
    logic             zero_n, valid_n;

    logic [2:0]       op_c;
    logic [WIDTH-1:0] alu_c;
    logic             slt_c;
    logic [WIDTH:0]   mul_sum_c;
    logic [WIDTH-1:0] mul_acc_c, mul_mq_c;
    logic [WIDTH:0]   div_sh_c;
    logic [WIDTH-1:0] div_diff_c, div_acc_c, div_mq_c;
    logic             div_ge_c;

    assign busy_o = (state != ST_IDLE);

    // Operation decode from ALUOp and funct
    always_comb begin
        op_c = OP_ADD;
        case (ALUOp_i)
            2'b00: op_c = OP_ADD;
            2'b01: op_c = OP_SUB;
            2'b11: op_c = OP_OR;
            default: begin
                case (funct_i)
                    6'b100000: op_c = OP_ADD;
                    6'b100010: op_c = OP_SUB;
                    6'b100100: op_c = OP_AND;
                    6'b100101: op_c = OP_OR;
                    6'b101010: op_c = OP_SLT;
                    6'b011000: op_c = OP_MUL;
                    6'b011011: op_c = OP_DIVU;
                    default:   op_c = OP_ADD;
                endcase
            end
        endcase
    end

    // Single-cycle datapath
    always_comb begin
        slt_c = ($signed(data1_i) < $signed(data2_i));
        alu_c = data1_i + data2_i;
        case (op_c)
            OP_SUB:  alu_c = data1_i - data2_i;
            OP_AND:  alu_c = data1_i & data2_i;
            OP_OR:   alu_c = data1_i | data2_i;
            OP_SLT:  alu_c = WIDTH'(slt_c);
            default: alu_c = data1_i + data2_i;
        endcase
    end

    // One shift-add multiply step and one restoring divide step
    always_comb begin
        mul_sum_c = {1'b0, acc} + (mq[0] ? {1'b0, opb} : {(WIDTH+1){1'b0}});
        mul_acc_c = mul_sum_c[WIDTH:1];
        mul_mq_c  = {mul_sum_c[0], mq[WIDTH-1:1]};

        div_sh_c   = {acc, mq[WIDTH-1]};
        div_ge_c   = (div_sh_c >= {1'b0, opb});
        div_diff_c = div_sh_c[WIDTH-1:0] - opb;
        div_acc_c  = div_ge_c ? div_diff_c : div_sh_c[WIDTH-1:0];
        div_mq_c   = {mq[WIDTH-2:0], div_ge_c};
    end

    // Next-state and next-output logic
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        acc_n    = acc;
        mq_n     = mq;
        opb_n    = opb;
        result_n = result_o;
        rem_n    = rem_o;
        zero_n   = zero_o;
        valid_n  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (valid_i) begin
                    if (op_c == OP_MUL) begin
                        state_n = ST_MUL;
                        cnt_n   = '0;
                        acc_n   = '0;
                        mq_n    = data2_i;
                        opb_n   = data1_i;
                    end else if (op_c == OP_DIVU) begin
                        state_n = ST_DIV;
                        cnt_n   = '0;
                        acc_n   = '0;
                        mq_n    = data1_i;
                        opb_n   = data2_i;
                    end else begin
                        result_n = alu_c;
                        rem_n    = '0;
                        zero_n   = (alu_c == '0);
                        valid_n  = 1'b1;
                    end
                end
            end
            ST_MUL: begin
                acc_n = mul_acc_c;
                mq_n  = mul_mq_c;
                cnt_n = cnt + CNT_W'(1);
                if (cnt == CNT_LAST) begin
                    result_n = mul_mq_c;
                    rem_n    = mul_acc_c;
                    zero_n   = (mul_mq_c == '0);
                    valid_n  = 1'b1;
                    state_n  = ST_IDLE;
                end
            end
            ST_DIV: begin
                acc_n = div_acc_c;
                mq_n  = div_mq_c;
                cnt_n = cnt + CNT_W'(1);
                if (cnt == CNT_LAST) begin
                    result_n = div_mq_c;
                    rem_n    = div_acc_c;
                    zero_n   = (div_mq_c == '0);
                    valid_n  = 1'b1;
                    state_n  = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) state <= ST_IDLE;
        else       state <= state_n;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt      <= '0;
            acc      <= '0;
            mq       <= '0;
            opb      <= '0;
            result_o <= '0;
            rem_o    <= '0;
            zero_o   <= 1'b0;
            valid_o  <= 1'b0;
        end else begin
            cnt      <= cnt_n;
            acc      <= acc_n;
            mq       <= mq_n;
            opb      <= opb_n;
            result_o <= result_n;
            rem_o    <= rem_n;
            zero_o   <= zero_n;
            valid_o  <= valid_n;
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: decode, single-cycle ops, MUL/DIVU latency,
// busy handling and reset abort.
module tb_alu_exec_unit;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        valid_i;
    logic [1:0]  ALUOp_i;
    logic [5:0]  funct_i;
    logic [31:0] data1_i;
    logic [31:0] data2_i;
    logic [31:0] result_o;
    logic [31:0] rem_o;
    logic        zero_o;
    logic        valid_o;
    logic        busy_o;

    int total = 0;
    int bad   = 0;

    alu_exec_unit #(.WIDTH(32)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i),
        .ALUOp_i(ALUOp_i), .funct_i(funct_i),
        .data1_i(data1_i), .data2_i(data2_i),
        .result_o(result_o), .rem_o(rem_o), .zero_o(zero_o),
        .valid_o(valid_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset;
        rst_i = 1'b1; valid_i = 1'b1; ALUOp_i = 2'b00; funct_i = 6'd0;
        data1_i = 32'd9; data2_i = 32'd9;
        tick; tick;
        total++; if (result_o !== 32'd0) begin bad++; $display("FAIL reset_result got=%h exp=0", result_o); end
        total++; if (rem_o !== 32'd0) begin bad++; $display("FAIL reset_rem got=%h exp=0", rem_o); end
        total++; if ({zero_o, valid_o, busy_o} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b exp=000", {zero_o, valid_o, busy_o}); end
        rst_i = 1'b0; valid_i = 1'b0;
        tick;
    endtask

    task automatic test_sub_zero;
        valid_i = 1'b1; ALUOp_i = 2'b10; funct_i = 6'b100010;
        data1_i = 32'd5; data2_i = 32'd5;
        tick;
        valid_i = 1'b0;
        total++; if (result_o !== 32'd0) begin bad++; $display("FAIL sub_result got=%h exp=0", result_o); end
        total++; if ({zero_o, valid_o, busy_o} !== 3'b110) begin bad++; $display("FAIL sub_flags got=%b exp=110", {zero_o, valid_o, busy_o}); end
        tick;
        total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL sub_pulse got=%b exp=0", valid_o); end
    endtask

    task automatic test_back_to_back;
        logic [1:0]  alu_v [4] = '{2'b00, 2'b10, 2'b10, 2'b10};
        logic [5:0]  fn_v  [4] = '{6'b000000, 6'b100100, 6'b100101, 6'b101010};
        logic [31:0] a_v   [4] = '{32'd3, 32'hF0, 32'hF0, 32'hFFFFFFFF};
        logic [31:0] b_v   [4] = '{32'd4, 32'h3C, 32'h0F, 32'd1};
        logic [31:0] exp_v [4] = '{32'd7, 32'h30, 32'hFF, 32'd1};
        for (int i = 0; i < 4; i++) begin
            valid_i = 1'b1; ALUOp_i = alu_v[i]; funct_i = fn_v[i];
            data1_i = a_v[i]; data2_i = b_v[i];
            tick;
            total++; if (valid_o !== 1'b1 || result_o !== exp_v[i] || rem_o !== 32'd0)
                begin bad++; $display("FAIL b2b_%0d got v=%b r=%h rem=%h exp v=1 r=%h rem=0", i, valid_o, result_o, rem_o, exp_v[i]); end
        end
        valid_i = 1'b0;
        tick;
        total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL b2b_end got=%b exp=0", valid_o); end
    endtask

    task automatic test_mul;
        int done_at = 0;
        bit busy_drop = 0;
        valid_i = 1'b1; ALUOp_i = 2'b10; funct_i = 6'b011000;
        data1_i = 32'hFFFFFFFF; data2_i = 32'd2;
        tick;
        valid_i = 1'b0; data1_i = 32'd0; data2_i = 32'd0;
        total++; if (busy_o !== 1'b1 || valid_o !== 1'b0) begin bad++; $display("FAIL mul_accept got busy=%b v=%b exp busy=1 v=0", busy_o, valid_o); end
        for (int n = 1; n <= 40 && done_at == 0; n++) begin
            valid_i = (n == 10);
            if (n == 10) begin ALUOp_i = 2'b00; data1_i = 32'd7; data2_i = 32'd8; end
            tick;
            valid_i = 1'b0;
            if (valid_o) done_at = n;
            else if (!busy_o) busy_drop = 1;
            if (n == 20) begin
                total++; if (result_o !== 32'd1) begin bad++; $display("FAIL mul_hold got=%h exp=1", result_o); end
            end
        end
        total++; if (done_at != 32) begin bad++; $display("FAIL mul_latency got=%0d exp=32", done_at); end
        total++; if (busy_drop) begin bad++; $display("FAIL mul_busy got=dropped exp=held"); end
        total++; if (result_o !== 32'hFFFFFFFE || rem_o !== 32'd1 || zero_o !== 1'b0 || busy_o !== 1'b0)
            begin bad++; $display("FAIL mul_result got r=%h rem=%h z=%b b=%b exp r=fffffffe rem=1 z=0 b=0", result_o, rem_o, zero_o, busy_o); end
        tick;
        total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL mul_pulse got=%b exp=0", valid_o); end
    endtask

    task automatic test_divu;
        logic [31:0] a_v [2] = '{32'd100, 32'd100};
        logic [31:0] b_v [2] = '{32'd7, 32'd0};
        logic [31:0] q_v [2] = '{32'd14, 32'hFFFFFFFF};
        logic [31:0] r_v [2] = '{32'd2, 32'd100};
        for (int i = 0; i < 2; i++) begin
            int done_at = 0;
            valid_i = 1'b1; ALUOp_i = 2'b10; funct_i = 6'b011011;
            data1_i = a_v[i]; data2_i = b_v[i];
            tick;
            valid_i = 1'b0;
            for (int n = 1; n <= 40 && done_at == 0; n++) begin
                tick;
                if (valid_o) done_at = n;
            end
            total++; if (done_at != 32) begin bad++; $display("FAIL div_latency_%0d got=%0d exp=32", i, done_at); end
            total++; if (result_o !== q_v[i] || rem_o !== r_v[i])
                begin bad++; $display("FAIL div_result_%0d got q=%h r=%h exp q=%h r=%h", i, result_o, rem_o, q_v[i], r_v[i]); end
        end
        tick;
    endtask

    task automatic test_reset_mid_mul;
        bit seen = 0;
        valid_i = 1'b1; ALUOp_i = 2'b10; funct_i = 6'b011000;
        data1_i = 32'd3; data2_i = 32'd5;
        tick;
        valid_i = 1'b0;
        repeat (14) tick;
        rst_i = 1'b1;
        tick;
        rst_i = 1'b0;
        total++; if (busy_o !== 1'b0 || valid_o !== 1'b0 || zero_o !== 1'b0 || result_o !== 32'd0 || rem_o !== 32'd0)
            begin bad++; $display("FAIL abort_state got b=%b v=%b z=%b r=%h rem=%h exp all 0", busy_o, valid_o, zero_o, result_o, rem_o); end
        valid_i = 1'b1; ALUOp_i = 2'b00; funct_i = 6'd0; data1_i = 32'd2; data2_i = 32'd3;
        tick;
        valid_i = 1'b0;
        total++; if (valid_o !== 1'b1 || result_o !== 32'd5 || busy_o !== 1'b0)
            begin bad++; $display("FAIL abort_add got v=%b r=%h b=%b exp v=1 r=5 b=0", valid_o, result_o, busy_o); end
        repeat (40) begin
            tick;
            if (valid_o) seen = 1;
        end
        total++; if (seen) begin bad++; $display("FAIL abort_no_pulse got=pulse exp=none"); end
    endtask

    task automatic test_aluop_override;
        logic [1:0]  alu_v [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
        logic [5:0]  fn_v  [4] = '{6'b011000, 6'b011000, 6'b011000, 6'b000000};
        logic [31:0] exp_v [4] = '{32'd13, 32'd7, 32'd11, 32'd13};
        data1_i = 32'd10; data2_i = 32'd3;
        for (int i = 0; i < 4; i++) begin
            valid_i = 1'b1; ALUOp_i = alu_v[i]; funct_i = fn_v[i];
            tick;
            total++; if (valid_o !== 1'b1 || busy_o !== 1'b0 || result_o !== exp_v[i])
                begin bad++; $display("FAIL override_%0d got v=%b b=%b r=%h exp v=1 b=0 r=%h", i, valid_o, busy_o, result_o, exp_v[i]); end
        end
        valid_i = 1'b0;
        tick;
    endtask

    initial begin
        test_reset;
        test_sub_zero;
        test_back_to_back;
        test_mul;
        test_divu;
        test_reset_mid_mul;
        test_aluop_override;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
